// File: rtl/pid_coeff_sched.sv
// ============================================================================
// Module   : pid_coeff_sched
// Purpose  : PID coefficient loader (4-bit nibble stream into shadow registers),
//            atomic commit at idle sample boundaries, sample strobe generator.
// Option   : PID_CFG_READBACK_EN adds a registered active-coefficient readback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pid_coeff_sched #(
    parameter int REG_BITWIDTH = 32,
    parameter int SAMPLE_DIV   = 1000,
    parameter int CNT_BITWIDTH = 10
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           run_i,
    input  logic                           pid_busy_i,
    input  logic                           cfg_valid_i,
    input  logic [3:0]                     cfg_nibble_i,
    output logic                           cfg_ready_o,
    output logic                           cfg_err_o,
    output logic                           clk_en_PID_o,
    output logic                           overrun_o,
    output logic                           commit_pending_o,
    output logic signed [REG_BITWIDTH-1:0] b0_reg_o,
    output logic signed [REG_BITWIDTH-1:0] b1_reg_o,
    output logic signed [REG_BITWIDTH-1:0] b2_reg_o,
    output logic signed [REG_BITWIDTH-1:0] a0_reg_o,
    output logic signed [REG_BITWIDTH-1:0] a1_reg_o
`ifdef PID_CFG_READBACK_EN
    ,
    input  logic [2:0]                     cfg_rd_addr_i,
    output logic [REG_BITWIDTH-1:0]        cfg_rdata_o
`endif
);

    localparam int NIB   = REG_BITWIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0]        c_last_idx = IDX_W'(NIB - 1);
    localparam logic [CNT_BITWIDTH-1:0] c_cnt_max  = CNT_BITWIDTH'(SAMPLE_DIV - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    state_t                   state_q,   state_d;
    logic [2:0]               sel_q,     sel_d;
    logic [IDX_W-1:0]         idx_q,     idx_d;
    logic [REG_BITWIDTH-1:0]  stage_q,   stage_d;
    logic [REG_BITWIDTH-1:0]  shadow_q [5];
    logic [REG_BITWIDTH-1:0]  shadow_d [5];
    logic [REG_BITWIDTH-1:0]  active_q [5];
    logic [REG_BITWIDTH-1:0]  active_d [5];
    logic                     pending_q, pending_d;
    logic                     err_q,     err_d;
    logic [CNT_BITWIDTH-1:0]  cnt_q,     cnt_d;
    logic                     clk_en_q,  clk_en_d;
    logic                     overrun_q, overrun_d;

    logic [REG_BITWIDTH-1:0]  w_word;
    logic                     w_wr;
    logic                     w_tick;
    logic                     w_commit;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        stage_d   = stage_q;
        err_d     = err_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        w_wr      = 1'b0;
        w_word    = REG_BITWIDTH'({stage_q, cfg_nibble_i});

        // cfg_ready_o is constantly 1, so cfg_valid_i alone qualifies a nibble
        if (cfg_valid_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_nibble_i < 4'd5) begin
                        state_d = ST_DATA;
                        sel_d   = cfg_nibble_i[2:0];
                        idx_d   = '0;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
                ST_DATA: begin
                    stage_d = w_word;
                    if (idx_q == c_last_idx) begin
                        w_wr    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        w_tick   = run_i && (cnt_q == c_cnt_max);
        w_commit = pending_q && !pid_busy_i && (w_tick || !run_i);
        cnt_d    = (!run_i || w_tick) ? '0 : cnt_q + CNT_BITWIDTH'(1);

        // Commit copies pre-edge shadow, so a word landing this edge stays pending
        if (w_commit) begin
            active_d = shadow_q;
        end
        for (int i = 0; i < 5; i++) begin
            if (w_wr && (sel_q == 3'(i))) begin
                shadow_d[i] = w_word;
            end
        end

        pending_d = w_wr | (pending_q & ~w_commit);
        clk_en_d  = w_tick & ~pid_busy_i;
        overrun_d = overrun_q | (w_tick & pid_busy_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            idx_q     <= '0;
            stage_q   <= '0;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            clk_en_q  <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            idx_q     <= idx_d;
            stage_q   <= stage_d;
            pending_q <= pending_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            clk_en_q  <= clk_en_d;
            overrun_q <= overrun_d;
            for (int i = 0; i < 5; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign cfg_ready_o      = 1'b1;
    assign cfg_err_o        = err_q;
    assign clk_en_PID_o     = clk_en_q;
    assign overrun_o        = overrun_q;
    assign commit_pending_o = pending_q;
    assign b0_reg_o         = active_q[0];
    assign b1_reg_o         = active_q[1];
    assign b2_reg_o         = active_q[2];
    assign a0_reg_o         = active_q[3];
    assign a1_reg_o         = active_q[4];

`ifdef PID_CFG_READBACK_EN
    logic [REG_BITWIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < 5; i++) begin
            if (cfg_rd_addr_i == 3'(i)) begin
                rdata_d = active_q[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign cfg_rdata_o = rdata_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pid_coeff_sched.sv
// ============================================================================
// Module   : tb_pid_coeff_sched
// Purpose  : Scoreboard bench for pid_coeff_sched (SAMPLE_DIV=10, 32-bit regs);
//            PID_CFG_READBACK_EN also exercises the readback port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pid_coeff_sched;

    localparam int REG_BITWIDTH = 32;
    localparam int SAMPLE_DIV   = 10;
    localparam int CNT_BITWIDTH = 10;

    logic clk = 1'b0;
    logic rst_i = 1'b1, run_i = 1'b0, pid_busy_i = 1'b0, cfg_valid_i = 1'b0;
    logic [3:0] cfg_nibble_i = '0;
    logic cfg_ready_o, cfg_err_o, clk_en_PID_o, overrun_o, commit_pending_o;
    logic [REG_BITWIDTH-1:0] b0_reg_o, b1_reg_o, b2_reg_o, a0_reg_o, a1_reg_o;
    logic [2:0]              rd_addr = '0;
    logic [REG_BITWIDTH-1:0] rdata;

    always #5 clk = ~clk;

    pid_coeff_sched #(
        .REG_BITWIDTH (REG_BITWIDTH),
        .SAMPLE_DIV   (SAMPLE_DIV),
        .CNT_BITWIDTH (CNT_BITWIDTH)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .run_i            (run_i),
        .pid_busy_i       (pid_busy_i),
        .cfg_valid_i      (cfg_valid_i),
        .cfg_nibble_i     (cfg_nibble_i),
        .cfg_ready_o      (cfg_ready_o),
        .cfg_err_o        (cfg_err_o),
        .clk_en_PID_o     (clk_en_PID_o),
        .overrun_o        (overrun_o),
        .commit_pending_o (commit_pending_o),
        .b0_reg_o         (b0_reg_o),
        .b1_reg_o         (b1_reg_o),
        .b2_reg_o         (b2_reg_o),
        .a0_reg_o         (a0_reg_o),
        .a1_reg_o         (a1_reg_o)
`ifdef PID_CFG_READBACK_EN
        ,
        .cfg_rd_addr_i    (rd_addr),
        .cfg_rdata_o      (rdata)
`endif
    );

`ifndef PID_CFG_READBACK_EN
    assign rdata = '0;
`endif

    typedef struct packed {
        logic en, ovr, err, pend, rdy;
        logic [4:0][REG_BITWIDTH-1:0] coef;
        logic [REG_BITWIDTH-1:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   started = 1'b0;

    // Reference model: integer sample position, arrays of words, frame progress
    bit                      m_in_frame;
    int                      m_sel, m_nibs, m_pos;
    logic [REG_BITWIDTH-1:0] m_word, m_rdata;
    logic [REG_BITWIDTH-1:0] m_shadow [5];
    logic [REG_BITWIDTH-1:0] m_active [5];
    bit                      m_pending, m_err, m_ovr, m_en;

    task automatic model_reset();
        m_in_frame = 0; m_sel = 0; m_nibs = 0; m_pos = 0; m_word = '0; m_rdata = '0;
        m_pending = 0; m_err = 0; m_ovr = 0; m_en = 0;
        for (int k = 0; k < 5; k++) begin
            m_shadow[k] = '0;
            m_active[k] = '0;
        end
    endtask

    task automatic model_edge(input bit rst, run, busy, valid, input logic [3:0] nib,
                              input logic [2:0] ra);
        bit tick, commit, wr;
        if (rst) begin
            model_reset();
            return;
        end
        m_rdata = (ra < 5) ? m_active[ra] : '0;
        tick    = run && (m_pos == SAMPLE_DIV - 1);
        commit  = m_pending && !busy && (tick || !run);
        if (commit) for (int k = 0; k < 5; k++) m_active[k] = m_shadow[k];
        wr = 0;
        if (valid) begin
            if (!m_in_frame) begin
                if (nib < 5) begin
                    m_in_frame = 1; m_sel = int'(nib); m_nibs = 0;
                end else begin
                    m_err = 1;
                end
            end else begin
                m_word = {m_word[REG_BITWIDTH-5:0], nib};
                m_nibs++;
                if (m_nibs == REG_BITWIDTH / 4) begin
                    m_shadow[m_sel] = m_word;
                    m_in_frame = 0;
                    wr = 1;
                end
            end
        end
        m_pending = wr ? 1'b1 : (commit ? 1'b0 : m_pending);
        m_en      = tick && !busy;
        m_ovr     = m_ovr || (tick && busy);
        m_pos     = !run ? 0 : (tick ? 0 : m_pos + 1);
    endtask

    task automatic step(input bit rst, run, busy, valid, input logic [3:0] nib);
        exp_t e;
        logic [2:0] ra;
        @(negedge clk);
        ra = 3'($urandom_range(0, 7));
        rst_i = rst; run_i = run; pid_busy_i = busy; cfg_valid_i = valid;
        cfg_nibble_i = nib; rd_addr = ra;
        model_edge(rst, run, busy, valid, nib, ra);
        e.en = m_en; e.ovr = m_ovr; e.err = m_err; e.pend = m_pending; e.rdy = 1'b1;
        for (int k = 0; k < 5; k++) e.coef[k] = m_active[k];
`ifdef PID_CFG_READBACK_EN
        e.rdata = m_rdata;
`else
        e.rdata = '0;
`endif
        sb_q.push_back(e);
        started = 1'b1;
    endtask

    task automatic idle(input int n, input bit run, busy);
        for (int i = 0; i < n; i++) step(0, run, busy, 0, 4'h0);
    endtask

    task automatic send_word(input logic [3:0] addr, input logic [REG_BITWIDTH-1:0] w,
                             input bit run, busy, gaps);
        step(0, run, busy, 1, addr);
        for (int i = REG_BITWIDTH / 4 - 1; i >= 0; i--) begin
            if (gaps && ($urandom_range(0, 3) == 0)) step(0, run, busy, 0, 4'hF);
            step(0, run, busy, 1, w[4*i +: 4]);
        end
    endtask

    task automatic wait_pos(input int p, input bit busy);
        for (int i = 0; i < 2 * SAMPLE_DIV && m_pos != p; i++) step(0, 1, busy, 0, 4'h0);
    endtask

    task automatic chk(input string nm, input logic [REG_BITWIDTH-1:0] act,
                       input logic [REG_BITWIDTH-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: one expected snapshot per clock edge once stimulus has begun
    initial begin
        exp_t e;
        logic [4:0][REG_BITWIDTH-1:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                if (sb_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL sb_underflow: got empty queue, expected an entry at %0t", $time);
                end else begin
                    e   = sb_q.pop_front();
                    act = {a1_reg_o, a0_reg_o, b2_reg_o, b1_reg_o, b0_reg_o};
                    chk("clk_en_PID", {31'b0, clk_en_PID_o}, {31'b0, e.en});
                    chk("overrun", {31'b0, overrun_o}, {31'b0, e.ovr});
                    chk("cfg_err", {31'b0, cfg_err_o}, {31'b0, e.err});
                    chk("commit_pending", {31'b0, commit_pending_o}, {31'b0, e.pend});
                    chk("cfg_ready", {31'b0, cfg_ready_o}, {31'b0, e.rdy});
                    for (int k = 0; k < 5; k++) chk($sformatf("coef%0d", k), act[k], e.coef[k]);
                    chk("rdata", rdata, e.rdata);
                end
            end
        end
    end

    initial begin
        model_reset();
        step(1, 0, 0, 0, 4'h0);
        step(1, 0, 0, 0, 4'h0);
        idle(35, 1, 0);                                // pulses every 10 cycles, coefs 0
        send_word(4'd2, 32'h12345678, 1, 0, 0);        // b2 commit at next tick
        idle(12, 1, 0);
        step(0, 1, 0, 1, 4'd7);                        // bad address
        for (int i = 0; i < 8; i++) step(0, 1, 0, 1, 4'($urandom_range(5, 15)));
        idle(3, 1, 0);
        send_word(4'd1, 32'hCAFE_0001, 1, 0, 1);       // busy across tick -> overrun
        idle(12, 1, 1);
        idle(12, 1, 0);
        wait_pos(1, 0);                                // a0 lands on tick edge
        send_word(4'd3, 32'hA0A0_5555, 1, 0, 0);
        step(0, 1, 1, 0, 4'h0);
        wait_pos(0, 1);                                // tick blocked by busy
        step(0, 1, 0, 0, 4'h0);
        send_word(4'd4, 32'h8765_4321, 1, 0, 0);       // a1 lands on tick, a0 commits
        idle(12, 1, 0);
        idle(3, 0, 0);                                 // halted: immediate commit
        send_word(4'd0, 32'hFFFF_FFFF, 0, 0, 0);
        idle(5, 0, 0);
        for (int i = 0; i < 500; i++) begin
            logic [3:0] nib;
            nib = m_in_frame ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
            step($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, nib);
        end
        idle(15, 1, 0);
        @(posedge clk);
        #3;
        if (sb_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_drain: got %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pid_coeff_sched.md
Name: pid_coeff_sched

Overview:
Configuration and sequencing controller for the PID core.
- Receives coefficient writes over a narrow 4-bit nibble stream, which suits pin-limited TinyTapeout IO.
- Holds the writes in shadow registers.
- Commits all five coefficients atomically, only at sample boundaries where the PID datapath is idle.
- Generates the periodic one-cycle PID clock-enable pulse and flags sample overruns.

Parameters:
REG_BITWIDTH, 32, width of each coefficient register; must be a multiple of 4.
SAMPLE_DIV, 1000, clk_i cycles per PID sample period; must be at least 2.
CNT_BITWIDTH, 10, width of the sample counter; must satisfy 2**CNT_BITWIDTH >= SAMPLE_DIV.

Ports:
clk_i  in  1  system clock; the only clock.
rst_i  in  1  synchronous, active-high reset.
run_i  in  1  1 = sample scheduling enabled; 0 = scheduler halted.
pid_busy_i  in  1  high while the PID multiply sequence is in progress.
cfg_valid_i  in  1  qualifies cfg_nibble_i; one nibble is accepted per cycle when cfg_ready_o=1.
cfg_nibble_i  in  4  configuration stream nibble.
cfg_ready_o  out  1  loader can accept a nibble.
cfg_err_o  out  1  sticky; set when a bad address nibble is received.
clk_en_PID_o  out  1  one-cycle sample strobe to the PID core.
overrun_o  out  1  sticky; set when a sample tick lands while pid_busy_i=1.
commit_pending_o  out  1  shadow holds uncommitted writes.
b0_reg_o, b1_reg_o, b2_reg_o, a0_reg_o, a1_reg_o  out  REG_BITWIDTH each  active coefficients, signed.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values:
  - All active and shadow registers 0.
  - Counter 0; loader state IDLE.
  - cfg_ready_o=1; cfg_err_o, clk_en_PID_o, overrun_o and commit_pending_o all 0.
- Reset asserted mid-frame aborts the frame. No partial write reaches shadow.

Loader FSM (states IDLE, DATA):
- A nibble is accepted in any cycle with cfg_valid_i=1 and cfg_ready_o=1. cfg_ready_o is 1 in both states; the loader never stalls.
- IDLE, accepted nibble = address:
  - Addresses 0..4 select b0, b1, b2, a0, a1 → go to DATA, nibble index = 0.
  - Addresses 5..15 → set cfg_err_o, stay in IDLE. The nibble is discarded.
- DATA: REG_BITWIDTH/4 nibbles, MSB nibble first, shift into a staging register.
  - On the last nibble, the full word is written to the selected shadow register at that edge.
  - The same edge sets commit_pending and returns to IDLE.
  - Gaps in cfg_valid_i are allowed mid-frame; the FSM waits.
- cfg_err_o clears only on reset.

Scheduler:
- run_i=0:
  - Counter held at 0; no clk_en_PID_o.
  - Pending commits apply on the next edge where pid_busy_i=0.
- run_i=1: counter counts 0..SAMPLE_DIV-1 and wraps to 0. A tick is the cycle where counter = SAMPLE_DIV-1.
- Tick with pid_busy_i=0:
  - If pending, active <= shadow for all five registers at the tick edge.
  - clk_en_PID_o=1 in the cycle after the tick, for exactly one cycle.
  - The PID therefore sees the new coefficients from its first multiply.
- Tick with pid_busy_i=1:
  - No pulse and no commit; commit_pending is retained.
  - overrun_o is set (sticky until reset).
  - The counter wraps normally.
- Write completing on the same edge as a commit:
  - The commit copies the pre-edge shadow contents.
  - The new word lands in shadow and commit_pending stays 1 for the next tick.
- Otherwise a commit clears commit_pending.
- Coefficient fields are committed as a set and never individually.

Latency:
- Last nibble → shadow write: 1 edge.
- Shadow → active: next idle tick, at most SAMPLE_DIV cycles while running.

Optional Feature:
Macro: PID_CFG_READBACK_EN.
- Defined:
  - Adds ports cfg_rd_addr_i (in, 3) and cfg_rdata_o (out, REG_BITWIDTH).
  - cfg_rdata_o is a registered readback of the active register at cfg_rd_addr_i, valid 1 cycle after the address is presented.
  - Addresses 5..7 return 0; reset value is 0.
- Undefined: these ports and their logic are absent.

Test Plan (bench uses SAMPLE_DIV=10, REG_BITWIDTH=32):
- Reset, run_i=1, pid_busy_i=0 → clk_en_PID_o pulses at cycles 10, 20, 30 after reset release, each 1 cycle wide; all coefficients read 0.
- Stream addr 2 then 0x12345678 as 8 nibbles while running → commit_pending_o=1, b2_reg_o stays 0 until the next tick edge, then reads 0x12345678 with commit_pending_o=0; pulse follows 1 cycle later.
- Address nibble 7, then 8 data nibbles → cfg_err_o=1; no shadow write. Each data nibble is parsed as an address (nibbles 0..4 start a new frame); the bench uses data nibbles ≥5 so the FSM stays in IDLE.
- Hold pid_busy_i=1 across a tick with a commit pending → no clk_en_PID_o, overrun_o=1, active unchanged. Drop busy → commit and pulse at the following tick.
- Complete a write to a1 on the exact tick cycle while an older write to a0 is pending → a0 committed, a1 still pending; a1 committed at the next tick.
- run_i=0, write b0=0xFFFFFFFF with pid_busy_i=0 → b0_reg_o updates 1 cycle after the shadow write; no clk_en_PID_o; counter stays 0.
